// File: rtl/cc_pkg.sv
// Shared defaults and FSM state encoding for the correlator sample feeder.
package cc_pkg;

    localparam int SAMPLE_W_DEF    = 16;
    localparam int NUM_SAMPLES_DEF = 1024;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_RESULT = 3'd4;

endpackage

// File: rtl/cc_sample_counter.sv
// Loadable wrapping read-address counter plus a sample counter whose terminal
// flag marks the last sample of a run.
module cc_sample_counter #(
    parameter int ADDR_W      = 18,
    parameter int NUM_SAMPLES = 1024
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_addr_en,
    input  logic              i_cnt_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam int              CNT_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    // Address wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
            r_cnt  <= '0;
        end else begin
            if (i_addr_en)
                r_addr <= r_addr + ADDR_W'(1);
            if (i_cnt_en)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/cc_sample_feeder.sv
// Streams NUM_SAMPLES dual-channel samples from memory into a correlator and hands back its lag.
// Define CC_FEEDER_TIMEOUT_EN to bound the wait for cc_done to TIMEOUT cycles.
module cc_sample_feeder
    import cc_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT     = 4096
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic [ADDR_W-1:0]          base_addr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd,
    input  logic [SAMPLE_W-1:0]        mem_a,
    input  logic [SAMPLE_W-1:0]        mem_b,
    output logic                       cc_start,
    output logic [SAMPLE_W-1:0]        cc_m0,
    output logic [SAMPLE_W-1:0]        cc_m1,
    input  logic                       cc_done,
    input  logic signed [SAMPLE_W-1:0] cc_index,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [SAMPLE_W-1:0] res_index,
    output logic                       res_err,
    output logic                       busy
);

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_W-1:0]          w_addr;
    logic                       w_last;
    logic                       w_idle;
    logic                       w_start;
    logic                       w_stream;
    logic                       w_wait;
    logic                       w_result;
    logic                       w_timeout;
    logic signed [SAMPLE_W-1:0] r_res_index;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_start  = (r_state == ST_START);
    assign w_stream = (r_state == ST_STREAM);
    assign w_wait   = (r_state == ST_WAIT);
    assign w_result = (r_state == ST_RESULT);

    // Loading in IDLE latches the base; START presents it and every START/STREAM cycle advances it.
    cc_sample_counter #(
        .ADDR_W      (ADDR_W),
        .NUM_SAMPLES (NUM_SAMPLES)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_idle & go),
        .i_base    (base_addr),
        .i_addr_en (w_start | w_stream),
        .i_cnt_en  (w_stream),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

`ifdef CC_FEEDER_TIMEOUT_EN
    localparam int               WT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WT_W-1:0]  WT_LAST = WT_W'(TIMEOUT - 1);

    logic [WT_W-1:0] r_wait_cnt;
    logic            r_res_err;

    always_ff @(posedge clk) begin
        if (!rst || !w_wait)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= r_wait_cnt + WT_W'(1);
    end

    assign w_timeout = w_wait && (r_wait_cnt == WT_LAST);

    // A cc_done in the final WAIT cycle wins over the timeout.
    always_ff @(posedge clk) begin
        if (!rst)
            r_res_err <= 1'b0;
        else if (w_wait && cc_done)
            r_res_err <= 1'b0;
        else if (w_timeout)
            r_res_err <= 1'b1;
    end

    assign res_err = r_res_err;
`else
    // TIMEOUT has no effect in this build: WAIT holds until cc_done.
    assign w_timeout = (TIMEOUT < 0);
    assign res_err   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (go)                   w_next = ST_START;
            ST_START:                            w_next = ST_STREAM;
            ST_STREAM: if (w_last)               w_next = ST_WAIT;
            ST_WAIT:   if (cc_done || w_timeout) w_next = ST_RESULT;
            ST_RESULT: if (res_ready)            w_next = ST_IDLE;
            default:                             w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_res_index <= '0;
        else if (w_wait && cc_done)
            r_res_index <= cc_index;
        else if (w_timeout)
            r_res_index <= '0;
    end

    assign mem_addr  = w_addr;
    assign mem_rd    = w_start | (w_stream & ~w_last);
    assign cc_start  = w_start;
    assign cc_m0     = w_stream ? mem_a : '0;
    assign cc_m1     = w_stream ? mem_b : '0;
    assign res_valid = w_result;
    assign res_index = r_res_index;
    assign busy      = ~w_idle;

endmodule

// File: tb/tb_cc_sample_feeder.sv
// Scoreboard bench for cc_sample_feeder: a driver queues expected runs and results,
// a negedge monitor compares the stream, addresses and results against a reference model.
module tb_cc_sample_feeder;

    localparam int N  = 1024;
    localparam int AW = 18;
    localparam int SW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [SW-1:0] mem_a = '0;
    logic [SW-1:0] mem_b = '0;
    logic          cc_start;
    logic [SW-1:0] cc_m0;
    logic [SW-1:0] cc_m1;
    logic          cc_done = 1'b0;
    logic [SW-1:0] cc_index = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [SW-1:0] res_index;
    logic          res_err;
    logic          busy;

    cc_sample_feeder #(
        .SAMPLE_W    (SW),
        .NUM_SAMPLES (N),
        .ADDR_W      (AW),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .base_addr (base_addr),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_a     (mem_a),
        .mem_b     (mem_b),
        .cc_start  (cc_start),
        .cc_m0     (cc_m0),
        .cc_m1     (cc_m1),
        .cc_done   (cc_done),
        .cc_index  (cc_index),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_index (res_index),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] cur_mul = 16'd1;
    logic [15:0] cur_off = 16'd0;
    logic [15:0] cur_dlt = 16'd3;

    typedef struct {
        logic [AW-1:0] base;
        logic [15:0]   mul;
        logic [15:0]   off;
        logic [15:0]   dlt;
    } run_t;

    typedef struct {
        logic [15:0] idx;
        logic        err;
        int          lat;
    } res_t;

    run_t run_q[$];
    res_t res_q[$];

    // Memory contents are a per-run affine function of the address.
    function automatic logic [15:0] samp(input logic [AW-1:0] a, input logic [15:0] mul,
                                         input logic [15:0] off);
        logic [15:0] lo;
        lo = a[15:0];
        return 16'(lo * mul + off);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One-cycle-latency sample memory.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_a <= samp(mem_addr, cur_mul, cur_off);
            mem_b <= samp(mem_addr, cur_mul, cur_off) + cur_dlt;
        end
    end

    run_t          cur_run;
    res_t          cur_res;
    bit            in_stream = 1'b0;
    bit            in_res    = 1'b0;
    bit            have_res  = 1'b0;
    int            k         = 0;
    int            wait_entry = 0;
    logic [AW-1:0] ea;
    logic [AW-1:0] ea_next;
    logic [15:0]   e0;
    logic [15:0]   e1;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            in_stream = 1'b0;
            in_res    = 1'b0;
            have_res  = 1'b0;
        end else begin
            if (cc_start) begin
                if (in_stream || run_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: cc_start=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    cur_run = run_q.pop_front();
                    chk("start_addr", 32'(mem_addr), 32'(cur_run.base));
                    chk("start_rd", 32'(mem_rd), 32'd1);
                    in_stream = 1'b1;
                    k = 0;
                end
            end else if (in_stream) begin
                ea      = cur_run.base + AW'(k);
                ea_next = ea + AW'(1);
                e0      = samp(ea, cur_run.mul, cur_run.off);
                e1      = e0 + cur_run.dlt;
                chk("stream_m0", 32'(cc_m0), 32'(e0));
                chk("stream_m1", 32'(cc_m1), 32'(e1));
                chk("stream_rd", 32'(mem_rd), (k < N - 1) ? 32'd1 : 32'd0);
                if (k < N - 1)
                    chk("stream_addr", 32'(mem_addr), 32'(ea_next));
                k++;
                if (k == N) begin
                    in_stream  = 1'b0;
                    wait_entry = cyc + 1;
                end
            end else begin
                chk("quiet_m", {cc_m0, cc_m1}, 32'h0);
            end

            if (res_valid) begin
                if (!in_res) begin
                    if (res_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: res_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        cur_res  = res_q.pop_front();
                        have_res = 1'b1;
                        chk("res_latency", 32'(cyc - wait_entry), 32'(cur_res.lat));
                    end
                    in_res = 1'b1;
                end
                if (have_res) begin
                    chk("res_index", 32'(res_index), 32'(cur_res.idx));
                    chk("res_err", 32'(res_err), 32'(cur_res.err));
                end
            end else begin
                in_res   = 1'b0;
                have_res = 1'b0;
            end
        end
    end

    task automatic start_run(input logic [AW-1:0] base, input logic [15:0] mul,
                             input logic [15:0] off, input logic [15:0] dlt);
        bit seen;
        seen = 1'b0;
        cur_mul = mul;
        cur_off = off;
        cur_dlt = dlt;
        @(posedge clk); #1;
        base_addr = base;
        go = 1'b1;
        run_q.push_back('{base, mul, off, dlt});
        @(posedge clk); #1;
        go = 1'b0;
        base_addr = AW'($urandom);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cc_start) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL start_timeout: cc_start=0 expected 1 within 20 cycles");
        end
    endtask

    // Called at the START negedge; drives cc_done d cycles into WAIT when give_done is set.
    task automatic finish_stream(input int d, input logic [15:0] idx, input bit pulse,
                                 input bit give_done);
        for (int p = 1; p <= N + 1 + d; p++) begin
            @(posedge clk); #1;
            if (give_done && p == N + 1 + d) begin
                res_q.push_back('{idx, 1'b0, d + 1});
                cc_done  = 1'b1;
                cc_index = idx;
            end else begin
                cc_done  = pulse && (p == 10);
                cc_index = 16'($urandom);
            end
        end
        @(posedge clk); #1;
        cc_done = 1'b0;
    endtask

    task automatic handshake(input int hold, input logic [15:0] idx);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < TO + 40 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL result_timeout: res_valid=0 expected 1");
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            go = 1'($urandom);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        go = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        go = 1'b0;
        @(negedge clk);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid", 32'(res_valid), 32'd0);
        chk("idle_hold_index", 32'(res_index), 32'(idx));
        @(negedge clk);
        chk("go_in_hs_ignored", 32'(busy), 32'd0);
    endtask

    task automatic full_run(input logic [AW-1:0] base, input logic [15:0] mul,
                            input logic [15:0] off, input logic [15:0] dlt, input int d,
                            input logic [15:0] idx, input int hold, input bit pulse);
        start_run(base, mul, off, dlt);
        finish_stream(d, idx, pulse, 1'b1);
        handshake(hold, idx);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_start"}, 32'(cc_start), 32'd0);
        chk({tag, "_m"}, {cc_m0, cc_m1}, 32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_index"}, 32'(res_index), 32'd0);
        chk({tag, "_err"}, 32'(res_err), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Ramp data, lag -3 two cycles into WAIT, result held 10 cycles.
        full_run(AW'(0), 16'd1, 16'd0, 16'd3, 2, 16'hFFFD, 10, 1'b0);

        // Address wrap at the top of memory, with a stray cc_done during STREAM.
        full_run(AW'(18'h3FFFE), 16'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 5), 16'($urandom), $urandom_range(0, 4), 1'b1);

        // Reset at STREAM sample 500, then a clean full run from the same base.
        b = AW'($urandom);
        start_run(b, 16'($urandom), 16'($urandom), 16'($urandom));
        for (int p = 1; p <= 501; p++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        full_run(b, 16'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 5), 16'($urandom), $urandom_range(0, 4), 1'($urandom));

        for (int r = 0; r < 2; r++)
            full_run(AW'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     $urandom_range(0, 5), 16'($urandom), $urandom_range(0, 4), 1'($urandom));

        // cc_done only during STREAM.
        start_run(AW'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        finish_stream(0, 16'h0, 1'b1, 1'b0);
`ifdef CC_FEEDER_TIMEOUT_EN
        res_q.push_back('{16'h0, 1'b1, TO});
        handshake(2, 16'h0);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("stuck_wait_valid", 32'(res_valid), 32'd0);
        end
        chk("stuck_wait_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("stuck_reset_busy", 32'(busy), 32'd0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("runs_left", 32'(run_q.size()), 32'd0);
        chk("results_left", 32'(res_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
